// File: rtl/mem_pkg.sv
// Shared types, constants and parameter helpers for the scratch/register store.
package mem_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam bit RD_WRITE = 1'b0;
  localparam bit RD_READ  = 1'b1;

  function automatic int lane_count(input int data_width);
    return data_width / 8;
  endfunction

  function automatic bit params_legal(input int data_width, input int rd_latency);
    return ((data_width % 8) == 0) && (data_width > 0) &&
           ((rd_latency == 1) || (rd_latency == 2));
  endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// Read-return pipeline: RD_LATENCY stages of valid/data; each data stage only
// loads behind a valid beat, so rd_data holds between results.
module mem_rd_pipe #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    RD_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data
);

  for (genvar gi = 0; gi < RD_LATENCY; gi++) begin : g_stage
    logic                  valid_reg;
    logic [DATA_WIDTH-1:0] data_reg;
    logic                  src_valid;
    logic [DATA_WIDTH-1:0] src_data;

    if (gi == 0) begin : g_head
      assign src_valid = in_valid;
      assign src_data  = in_data;
    end else begin : g_tail
      assign src_valid = g_stage[gi-1].valid_reg;
      assign src_data  = g_stage[gi-1].data_reg;
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        valid_reg <= 1'b0;
        data_reg  <= INIT_VALUE;
      end else begin
        valid_reg <= src_valid;
        if (src_valid) begin
          data_reg <= src_data;
        end
      end
    end
  end

  assign rd_valid = g_stage[RD_LATENCY-1].valid_reg;
  assign rd_data  = g_stage[RD_LATENCY-1].data_reg;

endmodule

// File: rtl/mem_bw_init.sv
// Single-port synchronous memory with valid/ready requests, byte-lane writes,
// configurable read latency and an INIT_VALUE fill sweep after reset or on request.
module mem_bw_init
  import mem_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 4,
  parameter int                    RD_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_rd_wr,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wr_data,
  input  logic [DATA_WIDTH/8-1:0] req_byte_en,
  input  logic                    init_req,
  output logic                    rd_valid,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    init_done
);

  localparam int                    LANES     = lane_count(DATA_WIDTH);
  localparam int                    DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  if (!params_legal(DATA_WIDTH, RD_LATENCY)) begin : g_bad_params
    $error("mem_bw_init: DATA_WIDTH must be a multiple of 8 and RD_LATENCY 1 or 2");
  end

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   init_ptr_reg, init_ptr_next;
  logic                    req_ready_reg;
  logic                    init_done_reg;
  logic                    accept, rd_accept, wr_accept, sweep_we;
  logic [LANES-1:0]        lane_we;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  assign accept    = req_valid && req_ready_reg;
  assign rd_accept = accept && (req_rd_wr == RD_READ);
  assign wr_accept = accept && (req_rd_wr == RD_WRITE);
  // Hold the array untouched while reset is asserted; the sweep starts on release.
  assign sweep_we  = (state_reg == INIT) && reset;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane_we
    assign lane_we[gi] = wr_accept && req_byte_en[gi];
  end

  always_comb begin
    state_next    = state_reg;
    init_ptr_next = init_ptr_reg;
    case (state_reg)
      INIT: begin
        init_ptr_next = init_ptr_reg + ADDR_WIDTH'(1);
        if (init_ptr_reg == LAST_ADDR) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (init_req) begin
          state_next    = INIT;
          init_ptr_next = '0;
        end
      end
      default: begin
        state_next    = INIT;
        init_ptr_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= INIT;
      init_ptr_reg  <= '0;
      req_ready_reg <= 1'b0;
      init_done_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      init_ptr_reg  <= init_ptr_next;
      req_ready_reg <= (state_next == RUN);
      init_done_reg <= (state_next == RUN);
    end
  end

  always_ff @(posedge clk) begin
    if (sweep_we) begin
      mem[init_ptr_reg] <= INIT_VALUE;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (lane_we[i]) begin
          mem[req_addr][8*i +: 8] <= req_wr_data[8*i +: 8];
        end
      end
    end
  end

  // The first pipe stage is the registered read port of the array.
  mem_rd_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .RD_LATENCY (RD_LATENCY),
    .INIT_VALUE (INIT_VALUE)
  ) u_rd_pipe (
    .clk      (clk),
    .reset    (reset),
    .in_valid (rd_accept),
    .in_data  (mem[req_addr]),
    .rd_valid (rd_valid),
    .rd_data  (rd_data)
  );

  assign req_ready = req_ready_reg;
  assign init_done = init_done_reg;

endmodule

// File: tb/tb_mem_bw_init.sv
// Directed bench: two instances (read latency 1 and 2) share one stimulus stream.
module tb_mem_bw_init;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_rd_wr = 1'b0;
  logic [3:0]  req_addr = '0;
  logic [31:0] req_wr_data = '0;
  logic [3:0]  req_byte_en = '0;
  logic        init_req = 1'b0;

  logic        ready1, done1, rv1;
  logic [31:0] rd1;
  logic        ready2, done2, rv2;
  logic [31:0] rd2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_bw_init #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .RD_LATENCY(1), .INIT_VALUE(32'hFFFF_FFFF)) u_dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready1), .req_rd_wr(req_rd_wr),
    .req_addr(req_addr), .req_wr_data(req_wr_data), .req_byte_en(req_byte_en), .init_req(init_req),
    .rd_valid(rv1), .rd_data(rd1), .init_done(done1)
  );

  mem_bw_init #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .RD_LATENCY(2), .INIT_VALUE(32'hFFFF_FFFF)) u_dut2 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready2), .req_rd_wr(req_rd_wr),
    .req_addr(req_addr), .req_wr_data(req_wr_data), .req_byte_en(req_byte_en), .init_req(init_req),
    .rd_valid(rv2), .rd_data(rd2), .init_done(done2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request for one edge; returns 1ns after that edge.
  task automatic issue(input logic rw, input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    req_valid   = 1'b1;
    req_rd_wr   = rw;
    req_addr    = a;
    req_wr_data = d;
    req_byte_en = be;
    step();
    $display("txn %s addr=%0d wdata=%h be=%b init_req=%0b ready1=%0b", rw ? "rd" : "wr", a, d, be, init_req, ready1);
    req_valid = 1'b0;
  endtask

  initial begin
    // Reset values
    #2 reset = 1'b0;
    step();
    step();
    chk("rst_ready1", 32'(ready1), 32'd0);
    chk("rst_done1", 32'(done1), 32'd0);
    chk("rst_rv1", 32'(rv1), 32'd0);
    chk("rst_rd1", rd1, 32'hFFFF_FFFF);
    chk("rst_rv2", 32'(rv2), 32'd0);
    chk("rst_rd2", rd2, 32'hFFFF_FFFF);

    // Power-up sweep: ready rises exactly 16 edges after release
    reset = 1'b1;
    repeat (15) step();
    chk("sweep_ready_15", 32'(ready1), 32'd0);
    chk("sweep_done_15", 32'(done1), 32'd0);
    step();
    chk("sweep_ready_16", 32'(ready1), 32'd1);
    chk("sweep_done_16", 32'(done1), 32'd1);
    chk("sweep_ready2_16", 32'(ready2), 32'd1);

    // Read every address back to back
    for (int a = 0; a < 16; a++) begin
      issue(1'b1, 4'(a), 32'h0, 4'h0);
      chk($sformatf("init_rv1_a%0d", a), 32'(rv1), 32'd1);
      chk($sformatf("init_rd1_a%0d", a), rd1, 32'hFFFF_FFFF);
      if (a > 0) begin
        chk($sformatf("init_rv2_a%0d", a - 1), 32'(rv2), 32'd1);
        chk($sformatf("init_rd2_a%0d", a - 1), rd2, 32'hFFFF_FFFF);
      end
    end
    step();
    chk("init_rv1_end", 32'(rv1), 32'd0);
    chk("init_rv2_a15", 32'(rv2), 32'd1);
    step();
    chk("init_rv2_end", 32'(rv2), 32'd0);

    // Byte-lane write, then zero-enable write as a no-op
    issue(1'b0, 4'd3, 32'h1234_5678, 4'b0101);
    chk("wr_no_rv1", 32'(rv1), 32'd0);
    issue(1'b0, 4'd3, 32'hDEAD_BEEF, 4'b0000);
    issue(1'b1, 4'd3, 32'h0, 4'h0);
    chk("be_rv1", 32'(rv1), 32'd1);
    chk("be_rd1", rd1, 32'hFF34_FF78);
    step();
    chk("be_rv1_low", 32'(rv1), 32'd0);
    chk("be_rd1_hold", rd1, 32'hFF34_FF78);
    chk("be_rv2", 32'(rv2), 32'd1);
    chk("be_rd2", rd2, 32'hFF34_FF78);
    step();
    chk("be_rv2_low", 32'(rv2), 32'd0);
    chk("be_rd2_hold", rd2, 32'hFF34_FF78);

    // Write at edge N, read same address at N+1
    issue(1'b0, 4'd7, 32'hA5A5_A5A5, 4'hF);
    issue(1'b1, 4'd7, 32'h0, 4'h0);
    chk("b2b_rv1", 32'(rv1), 32'd1);
    chk("b2b_rd1", rd1, 32'hA5A5_A5A5);
    chk("b2b_rv2_early", 32'(rv2), 32'd0);
    step();
    chk("b2b_rv1_low", 32'(rv1), 32'd0);
    chk("b2b_rv2", 32'(rv2), 32'd1);
    chk("b2b_rd2", rd2, 32'hA5A5_A5A5);
    step();

    // In-order return of three consecutive reads
    issue(1'b0, 4'd1, 32'h11, 4'hF);
    issue(1'b0, 4'd2, 32'h22, 4'hF);
    issue(1'b0, 4'd3, 32'h33, 4'hF);
    issue(1'b1, 4'd1, 32'h0, 4'h0);
    chk("ord_rd1_1", rd1, 32'h11);
    issue(1'b1, 4'd2, 32'h0, 4'h0);
    chk("ord_rd1_2", rd1, 32'h22);
    chk("ord_rd2_1", rd2, 32'h11);
    issue(1'b1, 4'd3, 32'h0, 4'h0);
    chk("ord_rv1_3", 32'(rv1), 32'd1);
    chk("ord_rd1_3", rd1, 32'h33);
    chk("ord_rd2_2", rd2, 32'h22);
    step();
    chk("ord_rv1_low", 32'(rv1), 32'd0);
    chk("ord_rv2_3", 32'(rv2), 32'd1);
    chk("ord_rd2_3", rd2, 32'h33);
    step();

    // Read together with init_req: read completes with pre-sweep data
    issue(1'b0, 4'd5, 32'h0, 4'hF);
    init_req = 1'b1;
    issue(1'b1, 4'd5, 32'h0, 4'h0);
    init_req = 1'b0;
    chk("reinit_rv1", 32'(rv1), 32'd1);
    chk("reinit_rd1", rd1, 32'h0);
    chk("reinit_ready_low", 32'(ready1), 32'd0);
    chk("reinit_done_low", 32'(done1), 32'd0);
    step();
    chk("reinit_rv2", 32'(rv2), 32'd1);
    chk("reinit_rd2", rd2, 32'h0);
    // Request and init_req during the sweep are both ignored
    init_req = 1'b1;
    issue(1'b1, 4'd5, 32'h0, 4'h0);
    init_req = 1'b0;
    chk("sweep_req_ignored", 32'(rv1), 32'd0);
    repeat (13) step();
    chk("reinit_ready_15", 32'(ready1), 32'd0);
    step();
    chk("reinit_ready_16", 32'(ready1), 32'd1);
    chk("reinit_ready2_16", 32'(ready2), 32'd1);
    issue(1'b1, 4'd5, 32'h0, 4'h0);
    chk("reinit_rd1_after", rd1, 32'hFFFF_FFFF);
    step();
    chk("reinit_rd2_after", rd2, 32'hFFFF_FFFF);

    // Reset with a read in flight, then reset again mid-sweep
    issue(1'b0, 4'd9, 32'h0, 4'hF);
    init_req = 1'b1;
    issue(1'b1, 4'd9, 32'h0, 4'h0);
    init_req = 1'b0;
    chk("rst_pend_rd1_before", rd1, 32'h0);
    reset = 1'b0;
    #1;
    chk("rst_pend_rv1", 32'(rv1), 32'd0);
    chk("rst_pend_rd1", rd1, 32'hFFFF_FFFF);
    chk("rst_pend_rv2", 32'(rv2), 32'd0);
    chk("rst_pend_rd2", rd2, 32'hFFFF_FFFF);
    step();
    step();
    chk("rst_pend_dropped", 32'(rv2), 32'd0);
    reset = 1'b1;
    repeat (5) step();
    reset = 1'b0;
    #1;
    chk("rst_mid_ready", 32'(ready1), 32'd0);
    chk("rst_mid_done", 32'(done1), 32'd0);
    step();
    reset = 1'b1;
    repeat (15) step();
    chk("rerun_ready_15", 32'(ready1), 32'd0);
    step();
    chk("rerun_ready_16", 32'(ready1), 32'd1);
    chk("rerun_done_16", 32'(done2), 32'd1);
    issue(1'b1, 4'd9, 32'h0, 4'h0);
    chk("rerun_rd1", rd1, 32'hFFFF_FFFF);
    step();
    chk("rerun_rv2", 32'(rv2), 32'd1);
    chk("rerun_rd2", rd2, 32'hFFFF_FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
